// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues req/ack data-memory transactions, builds byte
// enables, aligns/extends load data and forwards results to the MEM/WB register.
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_fp_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [4:0]        ex_rd_addr,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [2:0]        ex_funct3,
   input  logic              ex_wb_sel,
   input  logic              ex_wb_fp_en,
   input  logic              ex_wb_int_en,
   output logic [DATA_W-1:0] mem_load_data,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_fp_result,
   output logic [4:0]        mem_rd_addr,
   output logic              mem_wb_sel,
   output logic              mem_wb_fp_en,
   output logic              mem_wb_int_en,
   output logic              mem_stall,
   output logic              mem_fault,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;

   logic              is_access, sz_b, sz_h, sz_w, misalign, fault_cond, start;
   logic [3:0]        be_new;
   logic [DATA_W-1:0] wdata_new, lane_w, load_ext;
   logic              carry;

   // Access decode: size, alignment and legality of the instruction in EX/MEM.
   always_comb begin
      is_access  = ex_valid & (ex_mem_read | ex_mem_write);
      sz_b       = (ex_funct3[1:0] == 2'b00);
      sz_h       = (ex_funct3[1:0] == 2'b01);
      sz_w       = (ex_funct3 == 3'b010);
      misalign   = (sz_h & ex_alu_result[0]) | (sz_w & (ex_alu_result[1:0] != 2'b00));
      fault_cond = is_access & ((ex_mem_read & ex_mem_write) | ~(sz_b | sz_h | sz_w) | misalign);
      start      = is_access & ~fault_cond;

      be_new    = 4'b0000;
      wdata_new = ex_store_data;
      if (sz_b) begin
         be_new    = 4'b0001 << ex_alu_result[1:0];
         wdata_new = {4{ex_store_data[7:0]}};
      end else if (sz_h) begin
         be_new    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
         wdata_new = {2{ex_store_data[15:0]}};
      end else if (sz_w) begin
         be_new    = 4'b1111;
      end
   end

   // Read lane is picked by the byte offset captured when the request was issued.
   always_comb begin
      lane_w = dmem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{lane_w[7]}}, lane_w[7:0]};
         3'b100:  load_ext = {24'd0, lane_w[7:0]};
         3'b001:  load_ext = {{16{lane_w[15]}}, lane_w[15:0]};
         3'b101:  load_ext = {16'd0, lane_w[15:0]};
         default: load_ext = lane_w;
      endcase
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      f3_d          = f3_q;
      off_d         = off_q;
      mem_stall     = 1'b0;
      mem_fault     = 1'b0;
      mem_load_data = '0;
      carry         = ex_valid;

      case (state_q)
         IDLE: begin
            if (start) begin
               mem_stall = 1'b1;
               carry     = 1'b0;
               state_d   = WAIT;
               req_d     = 1'b1;
               we_d      = ex_mem_write;
               addr_d    = {ex_alu_result[ADDR_W-1:2], 2'b00};
               wdata_d   = wdata_new;
               be_d      = be_new;
               f3_d      = ex_funct3;
               off_d     = ex_alu_result[1:0];
            end else if (fault_cond) begin
               mem_fault = 1'b1;
               carry     = 1'b0;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               if (!we_q) mem_load_data = load_ext;
            end else begin
               mem_stall = 1'b1;
               carry     = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset abandons any pending access and silences all downstream effects.
      if (rst) begin
         state_d       = IDLE;
         req_d         = 1'b0;
         mem_stall     = 1'b0;
         mem_fault     = 1'b0;
         mem_load_data = '0;
         carry         = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   assign mem_alu_result = ex_alu_result;
   assign mem_fp_result  = ex_fp_result;
   assign mem_rd_addr    = ex_rd_addr;
   assign mem_wb_sel     = ex_wb_sel;
   assign mem_wb_fp_en   = carry & ex_wb_fp_en;
   assign mem_wb_int_en  = carry & ex_wb_int_en;
   assign dmem_req       = req_q;
   assign dmem_we        = we_q;
   assign dmem_addr      = addr_q;
   assign dmem_wdata     = wdata_q;
   assign dmem_be        = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: the bench plays upstream pipeline and data memory,
// and a behavioural model predicts every output on every cycle.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_sel, ex_wb_fp_en, ex_wb_int_en;
   logic [31:0] ex_alu_result, ex_fp_result, ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic [2:0]  ex_funct3;
   logic [31:0] mem_load_data, mem_alu_result, mem_fp_result;
   logic [4:0]  mem_rd_addr;
   logic        mem_wb_sel, mem_wb_fp_en, mem_wb_int_en, mem_stall, mem_fault;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
      .ex_fp_result(ex_fp_result), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
      .ex_wb_sel(ex_wb_sel), .ex_wb_fp_en(ex_wb_fp_en), .ex_wb_int_en(ex_wb_int_en),
      .mem_load_data(mem_load_data), .mem_alu_result(mem_alu_result),
      .mem_fp_result(mem_fp_result), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
      .mem_wb_fp_en(mem_wb_fp_en), .mem_wb_int_en(mem_wb_int_en), .mem_stall(mem_stall),
      .mem_fault(mem_fault), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   typedef struct {
      logic [31:0] a, fp, d;
      logic [4:0]  rdst;
      logic        v, r, w, sel, fpen, inten;
      logic [2:0]  f3;
   } instr_t;

   typedef struct {
      logic        stall, fault, int_en, fp_en, chk_load, req, chk_req, we;
      logic [31:0] load_data, addr, wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t        exp_c;
   bit          exp_on = 0;
   int          total = 0;
   int          bad = 0;
   int          stall_count;
   logic [31:0] last_load, last_wdata;
   logic [3:0]  last_be;
   logic        last_int_en, last_we, last_fault;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit is_fault(input instr_t i);
      int sz;
      if (!i.v || !(i.r || i.w)) return 0;
      if (i.r && i.w) return 1;
      sz = size_of(i.f3);
      if (sz == 0) return 1;
      return (int'(i.a[1:0]) % sz) != 0;
   endfunction

   function automatic bit is_mem(input instr_t i);
      return i.v && (i.r || i.w) && !is_fault(i);
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
      logic [3:0] b = 4'b0000;
      int off = int'(a[1:0]);
      for (int k = 0; k < size_of(f3); k++)
         if (off + k < 4) b[off + k] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
      logic [31:0] wd = 32'd0;
      int sz = size_of(f3);
      if (sz == 0) return d;
      for (int l = 0; l < 4; l++) wd[8*l +: 8] = d[8*(l % sz) +: 8];
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                              input logic [2:0] f3);
      logic [31:0] s, mask;
      int sz = size_of(f3);
      s = rdata >> (8 * int'(a[1:0]));
      if (sz == 4 || sz == 0) return s;
      mask = (32'd1 << (8 * sz)) - 32'd1;
      s = s & mask;
      if (!f3[2] && s[8*sz-1]) s = s | ~mask;
      return s;
   endfunction

   function automatic exp_t mem_exp(input instr_t i, input int k, input int d, input logic [31:0] rdata);
      exp_t e;
      e.stall     = (k < d);
      e.fault     = 1'b0;
      e.int_en    = (k == d) && i.inten;
      e.fp_en     = (k == d) && i.fpen;
      e.chk_load  = 1'b1;
      e.load_data = (k == d && i.r) ? model_load(rdata, i.a, i.f3) : 32'd0;
      e.chk_req   = 1'b1;
      e.req       = (k >= 1);
      e.we        = i.w;
      e.addr      = {i.a[31:2], 2'b00};
      e.be        = model_be(i.a, i.f3);
      e.wdata     = model_wdata(i.d, i.f3);
      return e;
   endfunction

   function automatic exp_t idle_exp(input instr_t i);
      exp_t e;
      bit f = is_fault(i);
      e.stall     = 1'b0;
      e.fault     = f;
      e.int_en    = i.v && !f && i.inten;
      e.fp_en     = i.v && !f && i.fpen;
      e.chk_load  = 1'b1;
      e.load_data = 32'd0;
      e.chk_req   = 1'b1;
      e.req       = 1'b0;
      e.we        = 1'b0;
      e.addr      = 32'd0;
      e.be        = 4'd0;
      e.wdata     = 32'd0;
      return e;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (exp_on) begin
         check("stall", {31'd0, mem_stall}, {31'd0, exp_c.stall});
         check("fault", {31'd0, mem_fault}, {31'd0, exp_c.fault});
         check("int_en", {31'd0, mem_wb_int_en}, {31'd0, exp_c.int_en});
         check("fp_en", {31'd0, mem_wb_fp_en}, {31'd0, exp_c.fp_en});
         check("alu_pass", mem_alu_result, ex_alu_result);
         check("fp_pass", mem_fp_result, ex_fp_result);
         check("rd_pass", {27'd0, mem_rd_addr}, {27'd0, ex_rd_addr});
         check("sel_pass", {31'd0, mem_wb_sel}, {31'd0, ex_wb_sel});
         if (exp_c.chk_load) check("load_data", mem_load_data, exp_c.load_data);
         if (exp_c.chk_req) begin
            check("req", {31'd0, dmem_req}, {31'd0, exp_c.req});
            if (exp_c.req) begin
               check("we", {31'd0, dmem_we}, {31'd0, exp_c.we});
               check("addr", dmem_addr, exp_c.addr);
               check("be", {28'd0, dmem_be}, {28'd0, exp_c.be});
               check("wdata", dmem_wdata, exp_c.wdata);
            end
         end
         if (mem_stall) stall_count++;
         else begin
            last_load   = mem_load_data;
            last_int_en = mem_wb_int_en;
         end
         if (dmem_req) begin
            last_be    = dmem_be;
            last_wdata = dmem_wdata;
            last_we    = dmem_we;
         end
         last_fault = mem_fault;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input instr_t i);
      ex_valid      = i.v;
      ex_alu_result = i.a;
      ex_fp_result  = i.fp;
      ex_store_data = i.d;
      ex_rd_addr    = i.rdst;
      ex_mem_read   = i.r;
      ex_mem_write  = i.w;
      ex_funct3     = i.f3;
      ex_wb_sel     = i.sel;
      ex_wb_fp_en   = i.fpen;
      ex_wb_int_en  = i.inten;
   endtask

   task automatic run_instr(input instr_t i, input int d, input logic [31:0] rdata_ack);
      drive(i);
      if (is_mem(i)) begin
         for (int k = 0; k <= d; k++) begin
            dmem_rdata = (k == d) ? rdata_ack : $urandom;
            dmem_ack   = (k == d) ? 1'b1 : ((k == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            exp_c      = mem_exp(i, k, d, dmem_rdata);
            exp_on     = 1;
            tick();
         end
      end else begin
         dmem_rdata = $urandom;
         dmem_ack   = 1'($urandom_range(0, 1));
         exp_c      = idle_exp(i);
         exp_on     = 1;
         tick();
      end
   endtask

   function automatic instr_t mk(input logic v, input logic r, input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d, input logic inten);
      instr_t i;
      i.v = v; i.r = r; i.w = w; i.f3 = f3; i.a = a; i.d = d; i.inten = inten;
      i.fp = 32'hF00D_0000 ^ a; i.rdst = 5'd7; i.sel = r; i.fpen = 1'b0;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int kind = $urandom_range(0, 9);
      logic [2:0] legal [5];
      legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;
      i.a     = $urandom;
      if ($urandom_range(0, 1) == 1) i.a[1:0] = 2'b00;
      i.fp    = $urandom;
      i.d     = $urandom;
      i.rdst  = 5'($urandom);
      i.v     = ($urandom_range(0, 9) != 0);
      i.r     = (kind < 3) || (kind == 9);
      i.w     = (kind >= 3 && kind < 6) || (kind == 9);
      i.f3    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
      i.sel   = 1'($urandom);
      i.fpen  = 1'($urandom);
      i.inten = 1'($urandom);
      return i;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      instr_t i;
      stall_count = 0;
      dmem_ack    = 1'b0;
      dmem_rdata  = 32'd0;

      // Reset with a load presented: no stall, no fault, no writeback, request regs clear.
      rst = 1'b1;
      drive(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b1));
      tick();
      exp_c = idle_exp(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h100, 32'd0, 1'b0));
      exp_c.chk_load = 1'b0;
      exp_on = 1;
      @(negedge clk);
      check("rst_we", {31'd0, dmem_we}, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", {28'd0, dmem_be}, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Model pins against hand-computed values.
      check("pin_lh", model_load(32'h8001_0000, 32'h2, 3'b001), 32'hFFFF_8001);
      check("pin_sb_be", {28'd0, model_be(32'h1, 3'b000)}, 32'h0000_0002);
      check("pin_sb_wd", model_wdata(32'h0000_00AB, 3'b000), 32'hABAB_ABAB);

      // LW, ack on the third waiting cycle.
      stall_count = 0;
      run_instr(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b1), 3, 32'hDEAD_BEEF);
      check("lw_stalls", stall_count, 3);
      check("lw_data", last_load, 32'hDEAD_BEEF);
      check("lw_int_en", {31'd0, last_int_en}, 32'd1);

      run_instr(mk(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1'b1), 1, 32'h8012_3456);
      check("lb_data", last_load, 32'hFFFF_FF80);
      run_instr(mk(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1'b1), 2, 32'h8012_3456);
      check("lbu_data", last_load, 32'h0000_0080);

      run_instr(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 1'b0), 1, 32'd0);
      check("sh_be", {28'd0, last_be}, 32'h0000_000C);
      check("sh_wdata", last_wdata, 32'h1234_1234);
      check("sh_we", {31'd0, last_we}, 32'd1);

      stall_count = 0;
      run_instr(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1'b1), 1, 32'd0);
      check("mis_fault", {31'd0, last_fault}, 32'd1);
      check("mis_stall", stall_count, 0);

      run_instr(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'd0, 1'b1), 1, 32'd0);
      check("add_int_en", {31'd0, last_int_en}, 32'd1);
      check("add_stall", stall_count, 0);

      // Reset while waiting; the late ack must not produce a writeback.
      i = mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 1'b1);
      drive(i);
      dmem_ack = 1'b0;
      exp_c = mem_exp(i, 0, 5, 32'd0);
      tick();
      exp_c = mem_exp(i, 1, 5, 32'd0);
      tick();
      rst = 1'b1;
      exp_c = idle_exp(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0));
      exp_c.chk_load = 1'b0;
      exp_c.chk_req  = 1'b0;
      tick();
      rst = 1'b0;
      i = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h200, 32'd0, 1'b1);
      drive(i);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1357_9BDF;
      exp_c = idle_exp(i);
      tick();
      check("rst_wait_int_en", {31'd0, last_int_en}, 32'd0);
      check("rst_wait_load", last_load, 32'd0);

      for (int n = 0; n < 400; n++) begin
         run_instr(rand_instr(), $urandom_range(1, 4), $urandom);
      end

      exp_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
